// File: rtl/cfg_seq_pkg.sv
// Shared types and helpers for the fabric configuration sequencer.
package cfg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SYNC       = 3'd1,
        LOAD       = 3'd2,
        PARITY     = 3'd3,
        ERROR      = 3'd4,
        CONFIGURED = 3'd5,
        RUN        = 3'd6
    } t_cfg_seq_state;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    // Frame length for one CLB: per-input routing/config fields plus the LUT truth table.
    function automatic int clb_cfg_bits(input int lut_width);
        return lut_width * 10 + (1 << lut_width);
    endfunction

endpackage

// File: rtl/cfg_sync_detect.sv
// Sync-word hunter: MSB-first shift register, match detect and saturating bit
// counter that flags a timeout when no sync word shows up in time.
module cfg_sync_detect
    import cfg_seq_pkg::*;
#(
    parameter int                SYNC_W        = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD     = SYNC_W'(DEFAULT_SYNC_WORD),
    parameter int                MAX_SYNC_BITS = 64
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_match,
    output logic o_timeout
);

    localparam int CNT_W = $clog2(MAX_SYNC_BITS + 1);

    // Only SYNC_W-1 bits of history are stored; the incoming bit completes the word.
    logic [SYNC_W-2:0] r_hist;
    logic [CNT_W-1:0]  r_cnt;
    logic [SYNC_W-1:0] w_word;
    logic [CNT_W:0]    w_cnt_inc;
    logic              w_word_hit;

    assign w_word     = {r_hist, i_bit};
    assign w_cnt_inc  = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_word_hit = (w_word == SYNC_WORD) && (w_cnt_inc >= (CNT_W+1)'(SYNC_W));
    assign o_match    = i_shift && w_word_hit;
    assign o_timeout  = i_shift && !w_word_hit && (w_cnt_inc >= (CNT_W+1)'(MAX_SYNC_BITS));

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_hist <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_hist <= w_word[SYNC_W-2:0];
            if (r_cnt != CNT_W'(MAX_SYNC_BITS))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cfg_sequencer.sv
// Fabric configuration controller: finds the sync word, streams one frame per CLB,
// then gates the run enable. Optional per-frame even parity via CFG_SEQ_PARITY_EN.
module cfg_sequencer
    import cfg_seq_pkg::*;
#(
    parameter int                NUM_CLBS      = 4,
    parameter int                CLB_CFG_BITS  = clb_cfg_bits(3),
    parameter int                SYNC_W        = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD     = SYNC_W'(DEFAULT_SYNC_WORD),
    parameter int                MAX_SYNC_BITS = 64
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_bs_valid,
    input  logic                i_bs_data,
    output logic                o_bs_ready,
    output logic [NUM_CLBS-1:0] o_clb_cfg,
    output logic                o_clb_cfg_data,
    input  logic                i_run_req,
    output logic                o_run,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int              IDX_W    = (NUM_CLBS > 1) ? $clog2(NUM_CLBS) : 1;
    localparam int              BIT_W    = $clog2(CLB_CFG_BITS);
    localparam logic [IDX_W-1:0] LAST_CLB = IDX_W'(NUM_CLBS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CLB_CFG_BITS - 1);

    t_cfg_seq_state   r_state;
    logic [IDX_W-1:0] r_clb_idx;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_bs_ready;
    logic             r_run;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
`ifdef CFG_SEQ_PARITY_EN
    logic             r_parity;
`endif

    logic w_accept;
    logic w_load;
    logic w_restart;
    logic w_sync_match;
    logic w_sync_timeout;

    assign w_accept  = i_bs_valid && r_bs_ready;
    assign w_load    = (r_state == LOAD);
    assign w_restart = i_start && ((r_state == IDLE) || (r_state == CONFIGURED) ||
                                   (r_state == RUN)  || (r_state == ERROR));

    cfg_sync_detect #(
        .SYNC_W        (SYNC_W),
        .SYNC_WORD     (SYNC_WORD),
        .MAX_SYNC_BITS (MAX_SYNC_BITS)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_restart),
        .i_shift   (w_accept && (r_state == SYNC)),
        .i_bit     (i_bs_data),
        .o_match   (w_sync_match),
        .o_timeout (w_sync_timeout)
    );

    // Strobes are combinational so the CLB captures the bit in the same cycle it is accepted.
    always_comb begin
        o_clb_cfg = '0;
        for (int i = 0; i < NUM_CLBS; i++)
            o_clb_cfg[i] = w_load && i_bs_valid && (r_clb_idx == IDX_W'(i));
    end

    assign o_clb_cfg_data = w_load && w_accept && i_bs_data;
    assign o_bs_ready     = r_bs_ready;
    assign o_run          = r_run;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_clb_idx  <= '0;
            r_bit_cnt  <= '0;
            r_bs_ready <= 1'b0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef CFG_SEQ_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (w_restart) begin
            r_state    <= SYNC;
            r_bs_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_run      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_sync_match) begin
                        r_state   <= LOAD;
                        r_clb_idx <= '0;
                        r_bit_cnt <= '0;
`ifdef CFG_SEQ_PARITY_EN
                        r_parity  <= 1'b0;
`endif
                    end else if (w_sync_timeout) begin
                        r_state    <= IDLE;
                        r_bs_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
`ifdef CFG_SEQ_PARITY_EN
                        r_parity <= r_parity ^ i_bs_data;
`endif
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
`ifdef CFG_SEQ_PARITY_EN
                            r_state   <= PARITY;
`else
                            if (r_clb_idx == LAST_CLB) begin
                                r_state    <= CONFIGURED;
                                r_bs_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_clb_idx <= r_clb_idx + IDX_W'(1);
                            end
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
`ifdef CFG_SEQ_PARITY_EN
                PARITY: begin
                    if (w_accept) begin
                        if (r_parity ^ i_bs_data) begin
                            r_state    <= ERROR;
                            r_bs_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_parity <= 1'b0;
                            if (r_clb_idx == LAST_CLB) begin
                                r_state    <= CONFIGURED;
                                r_bs_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_state   <= LOAD;
                                r_clb_idx <= r_clb_idx + IDX_W'(1);
                            end
                        end
                    end
                end
`endif
                CONFIGURED: begin
                    r_run <= i_run_req;
                    if (i_run_req)
                        r_state <= RUN;
                end
                RUN: begin
                    r_run <= i_run_req;
                    if (!i_run_req)
                        r_state <= CONFIGURED;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_sequencer.sv
// Directed self-checking bench for cfg_sequencer (covers the CFG_SEQ_PARITY_EN build too).
module tb_cfg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_bs_valid = 1'b0;
    logic       i_bs_data = 1'b0;
    logic       o_bs_ready;
    logic [3:0] o_clb_cfg;
    logic       o_clb_cfg_data;
    logic       i_run_req = 1'b0;
    logic       o_run;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] lastCfg;
    logic       lastData;
    logic       lastDone;
    logic       runSeen;
    int         pulses[4];
    int         badStrobe;

    always #5 clk = ~clk;

    cfg_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_bs_valid     (i_bs_valid),
        .i_bs_data      (i_bs_data),
        .o_bs_ready     (o_bs_ready),
        .o_clb_cfg      (o_clb_cfg),
        .o_clb_cfg_data (o_clb_cfg_data),
        .i_run_req      (i_run_req),
        .o_run          (o_run),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one bitstream cycle on the falling edge and snapshots the combinational strobes.
    task automatic applyStimulus(input logic valid, input logic data);
        @(negedge clk);
        i_bs_valid = valid;
        i_bs_data  = data;
        #1;
        lastCfg  = o_clb_cfg;
        lastData = o_clb_cfg_data;
        lastDone = o_done;
        runSeen  = runSeen | o_run;
        @(posedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            applyStimulus(1'b1, b[i]);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        i_bs_valid = 1'b0;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Streams four 38-bit frames; frames after a corrupted one must see no strobes at all.
    task automatic loadFabric(input bit stall, input int corruptClb);
        logic       b;
        logic       par;
        logic [3:0] expCfg;
        badStrobe = 0;
        runSeen   = 1'b0;
        pulses    = '{default: 0};
        for (int c = 0; c < 4; c++) begin
            par = 1'b0;
            expCfg = (corruptClb >= 0 && c > corruptClb) ? 4'b0000 : 4'(1 << c);
            for (int k = 0; k < 38; k++) begin
                b = 1'($urandom);
                if (stall) begin
                    applyStimulus(1'b0, ~b);
                    if (lastCfg !== 4'b0000 || lastData !== 1'b0)
                        badStrobe++;
                end
                applyStimulus(1'b1, b);
                par = par ^ b;
                if (lastCfg !== expCfg || (expCfg != 4'b0000 && lastData !== b))
                    badStrobe++;
                for (int j = 0; j < 4; j++)
                    if (lastCfg[j] === 1'b1)
                        pulses[j]++;
            end
`ifdef CFG_SEQ_PARITY_EN
            applyStimulus(1'b1, (c == corruptClb) ? ~par : par);
            if (lastCfg !== 4'b0000)
                badStrobe++;
`endif
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_bs_ready", o_bs_ready, 0);
        checkOutput("reset_clb_cfg", o_clb_cfg, 0);
        checkOutput("reset_cfg_data", o_clb_cfg_data, 0);
        checkOutput("reset_run", o_run, 0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_err", o_err, 0);
        rst_n = 1'b1;

        // Plain sync and load, with run requested throughout to prove gating.
        i_run_req = 1'b1;
        pulseStart();
        checkOutput("start_busy", o_busy, 1);
        checkOutput("start_bs_ready", o_bs_ready, 1);
        sendByte(8'hA5);
        #1;
        checkOutput("sync_to_clb0", o_clb_cfg, 4'b0001);
        loadFabric(1'b0, -1);
        checkOutput("load_bad_strobes", badStrobe, 0);
        checkOutput("load_pulses_clb0", pulses[0], 38);
        checkOutput("load_pulses_clb1", pulses[1], 38);
        checkOutput("load_pulses_clb2", pulses[2], 38);
        checkOutput("load_pulses_clb3", pulses[3], 38);
        checkOutput("run_gated_in_load", runSeen, 0);
        checkOutput("done_low_last_bit", lastDone, 0);
        #1;
        checkOutput("done_after_load", o_done, 1);
        checkOutput("run_lags_done", o_run, 0);
        checkOutput("ready_after_load", o_bs_ready, 0);
        checkOutput("busy_after_load", o_busy, 0);
        @(posedge clk);
        #1;
        checkOutput("run_enabled", o_run, 1);
        pulseStart();
        checkOutput("restart_run_drop", o_run, 0);
        checkOutput("restart_done_clear", o_done, 0);
        checkOutput("restart_bs_ready", o_bs_ready, 1);
        checkOutput("restart_busy", o_busy, 1);
        i_run_req = 1'b0;

        // Garbage prefix before the sync word, then a stalled load.
        begin
            logic [12:0] garbage;
            garbage = 13'b1100110011001;
            for (int i = 12; i >= 0; i--)
                applyStimulus(1'b1, garbage[i]);
        end
        #1;
        checkOutput("garbage_no_sync", o_clb_cfg, 4'b0000);
        sendByte(8'hA5);
        #1;
        checkOutput("garbage_sync_clb0", o_clb_cfg, 4'b0001);
        loadFabric(1'b1, -1);
        checkOutput("stall_bad_strobes", badStrobe, 0);
        checkOutput("stall_total_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3], 152);
        checkOutput("stall_pulses_clb0", pulses[0], 38);
        #1;
        checkOutput("stall_done", o_done, 1);
        checkOutput("stall_err", o_err, 0);

        // Sync timeout after 64 accepted bits without a match.
        pulseStart();
        repeat (63) applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("timeout_err_63", o_err, 0);
        checkOutput("timeout_ready_63", o_bs_ready, 1);
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("timeout_err", o_err, 1);
        checkOutput("timeout_ready", o_bs_ready, 0);
        checkOutput("timeout_busy", o_busy, 0);
        pulseStart();
        checkOutput("timeout_err_cleared", o_err, 0);
        checkOutput("timeout_restart_ready", o_bs_ready, 1);

        // Reset in the middle of a frame.
        sendByte(8'hA5);
        repeat (5) applyStimulus(1'b1, 1'b1);
        checkOutput("midload_strobe", lastCfg, 4'b0001);
        @(negedge clk);
        i_bs_valid = 1'b1;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_clb_cfg", o_clb_cfg, 4'b0000);
        checkOutput("midreset_ready", o_bs_ready, 0);
        checkOutput("midreset_busy", o_busy, 0);
        rst_n = 1'b1;

`ifdef CFG_SEQ_PARITY_EN
        // Bad parity on CLB 2 must stop delivery before CLB 3.
        pulseStart();
        sendByte(8'hA5);
        loadFabric(1'b0, 2);
        checkOutput("parity_bad_strobes", badStrobe, 0);
        checkOutput("parity_pulses_clb2", pulses[2], 38);
        checkOutput("parity_pulses_clb3", pulses[3], 0);
        #1;
        checkOutput("parity_err", o_err, 1);
        checkOutput("parity_done", o_done, 0);
        checkOutput("parity_ready", o_bs_ready, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_sequencer.md
Name: cfg_sequencer

Overview:
- Top-level configuration controller for the tiny-FPGA fabric.
- Accepts a single serial bitstream from the chip pins and finds a sync word.
- Delivers one fixed-length frame to each CLB in turn over a shared data line with per-CLB one-hot cfg strobes.
- Gates the fabric-wide run signal once every CLB is configured.

Parameters:
- NUM_CLBS, 4: number of CLBs served; frames are delivered to CLB 0 first, then in ascending index order.
- CLB_CFG_BITS, 38: bits per CLB frame, i.e. LUT_WIDTH*(2+8) + 2^LUT_WIDTH; the default is for LUT_WIDTH=3.
- SYNC_W, 8: sync word width.
- SYNC_WORD, 8'hA5: pattern preceding the first frame.
- MAX_SYNC_BITS, 64: accepted bits allowed in SYNC before an error is flagged.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request to begin (re)configuration
- bs_valid  in  1  bitstream bit valid
- bs_data  in  1  bitstream bit
- bs_ready  out  1  sequencer accepts a bit this cycle
- clb_cfg  out  NUM_CLBS  one-hot per-CLB strobe; the CLB consumes clb_cfg_data when its bit is high
- clb_cfg_data  out  1  shared config data line
- run_req  in  1  user request to run the fabric
- run  out  1  fabric run enable
- busy  out  1  in SYNC or LOAD (PARITY when enabled)
- done  out  1  configuration complete and valid
- err  out  1  sticky error flag

Behaviour:
- Reset values: state=IDLE; bs_ready=0, clb_cfg=0, clb_cfg_data=0, run=0, busy=0, done=0, err=0; all counters and the sync shift register are 0.
- Transfer rule: a bit is accepted only when bs_valid && bs_ready. bs_ready=1 exactly in SYNC and LOAD (and PARITY).
- States:
  - IDLE: on start, go to SYNC and clear err.
  - SYNC: per accepted bit, sr <= {sr[SYNC_W-2:0], bs_data} (MSB first) and sync_cnt++. If the new sr == SYNC_WORD with sync_cnt+1 >= SYNC_W, go to LOAD next cycle with clb_idx=0 and bit_cnt=0. If sync_cnt reaches MAX_SYNC_BITS with no match, set err=1 and go to IDLE.
  - LOAD:
    - clb_cfg[clb_idx] = bs_valid (combinational, same cycle as acceptance); clb_cfg_data = bs_data when accepted, else 0.
    - Other clb_cfg bits are always 0. When bs_valid is low, nothing advances (stall); no bits are lost or duplicated.
    - On acceptance with bit_cnt == CLB_CFG_BITS-1: bit_cnt wraps to 0.
    - Then, without the parity feature: if clb_idx == NUM_CLBS-1, go to CONFIGURED; else clb_idx++.
  - CONFIGURED: done=1; run is registered, run <= run_req (1-cycle latency); go to RUN when run_req=1.
  - RUN: run <= run_req. If run_req drops, go to CONFIGURED.
- start while in CONFIGURED/RUN: run drops to 0 on the next cycle, done clears, go to SYNC (reconfiguration).
- start while in SYNC/LOAD/PARITY: ignored.
- Simultaneous start and run_req in CONFIGURED: start wins.
- Reset mid-LOAD: returns to IDLE the next cycle, all strobes 0. CLBs are reset by the same rst_n.
- Widths:
  - clb_idx is max(1,$clog2(NUM_CLBS)) bits.
  - bit_cnt is $clog2(CLB_CFG_BITS) bits.
  - sync_cnt is $clog2(MAX_SYNC_BITS+1) bits and saturates.
- Full-fabric load latency with continuous valid: NUM_CLBS*CLB_CFG_BITS accepted cycles plus 1 state-change cycle after sync.

Optional Feature:
- Macro CFG_SEQ_PARITY_EN.
- Defined: each frame is followed by one parity bit in state PARITY. bs_ready=1 in PARITY and all clb_cfg bits are 0.
  - A running XOR of the frame bits plus the parity bit must be 0 (even parity).
  - If it is 0: advance to the next CLB or to CONFIGURED.
  - If it is 1: set err=1 and go to ERROR. In ERROR, done=0, run=0 and bs_ready=0; only start (to SYNC) or reset exits.
- Undefined: no PARITY or ERROR states; frames are back-to-back.

Decomposition:
- Package cfg_seq_pkg holds:
  - the t_cfg_seq_state enum (IDLE, SYNC, LOAD, PARITY, ERROR, CONFIGURED, RUN), 3 bits;
  - the default SYNC_WORD;
  - the function clb_cfg_bits(lut_width) returning lut_width*10 + (1<<lut_width).
- One sub-module: cfg_sync_detect, which holds the shift register, match logic and saturating bit counter with the timeout flag.

Test Plan:
- Sync and load: start, stream 0xA5 then 4x38 bits with bs_valid=1 → exactly 152 clb_cfg pulses, 38 per index in order 0..3; data matches the stream; done=1 one cycle after the last bit.
- Garbage prefix: 13 random bits (no 0xA5) then 0xA5 → sync found, first frame bit goes to CLB 0; err=0.
- Sync timeout: 64 bits of 0 → err=1, state IDLE, bs_ready=0; a following start clears err.
- Stall: toggle bs_valid every other cycle during LOAD → clb_cfg is high only on valid cycles; bit_cnt holds; the total pulse count is still 152.
- Run gating: run_req=1 during LOAD → run stays 0; after done, run=1 one cycle later. A start in RUN drops run the next cycle and bs_ready=1.
- With CFG_SEQ_PARITY_EN: a corrupted parity bit on CLB 2 → err=1, ERROR, done=0, and CLB 3 receives no clb_cfg pulses.
